// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file dump path.
// The beat struct is the (index, value, last) record streamed to the sink.
package regfile_pkg;

  localparam int DefaultXLen      = 32;
  localparam int DefaultNReg      = 32;
  localparam int DefaultNRegWidth = $clog2(DefaultNReg);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMP  = 2'd1,
    DRAIN = 2'd2
  } dump_state_e;

  typedef struct packed {
    logic [DefaultNRegWidth-1:0] addr;
    logic [DefaultXLen-1:0]      data;
    logic                        last;
  } dump_beat_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks the integer register file through its asynchronous read port and
// streams (index, value) beats over a valid/ready interface.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter  int XLen      = DefaultXLen,
  parameter  int NReg      = DefaultNReg,
  localparam int NRegWidth = $clog2(NReg)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NRegWidth-1:0] rf_addr_o,
  input  logic [XLen-1:0]      rf_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [NRegWidth-1:0] m_addr_o,
  output logic [XLen-1:0]      m_data_o,
  output logic                 m_last_o
);

  localparam logic [NRegWidth-1:0] LastIdx = NRegWidth'(NReg - 1);

  // Same field layout as dump_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [NRegWidth-1:0] addr;
    logic [XLen-1:0]      data;
    logic                 last;
  } beat_t;

  dump_state_e          state_q, state_d;
  logic [NRegWidth-1:0] idx_q, idx_d;
  beat_t                beat_q, beat_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 load;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    accept  = valid_q && m_ready_i;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          valid_d = 1'b0;
        end
        if (start_i) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end

      // The output register refills whenever it is empty or being drained,
      // so a continuously ready sink sees one beat per cycle.
      DUMP: begin
        load = !valid_q || m_ready_i;
        if (load) begin
          beat_d.addr = idx_q;
          beat_d.data = rf_data_i;
          beat_d.last = (idx_q == LastIdx);
          valid_d     = 1'b1;
          idx_d       = idx_q + NRegWidth'(1);
          if (idx_q == LastIdx) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (accept) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign rf_addr_o = (state_q == DUMP) ? idx_q : '0;
  assign m_valid_o = valid_q;
  assign m_addr_o  = beat_q.addr;
  assign m_data_o  = beat_q.data;
  assign m_last_o  = beat_q.last;

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug/verification block that reads the entire integer register file through one asynchronous read port and streams `(index, value)` pairs out over a valid/ready interface. It sits beside the register file, sharing a read-address mux slot with the core. It is the reading counterpart of the regfile's write port: test benches and the debug path use it to snapshot architectural state without touching the core's write port.

## Interface

Parameters:
- `XLen`, 32: data width of each register.
- `NReg`, 32: number of registers to dump. Must be a power of two, ≥ 2.
- `NRegWidth`, `$clog2(NReg)`: localparam, address width.

Ports:
- `clk_i`, input, 1: single clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `start_i`, input, 1: request a full dump. Sampled only in IDLE.
- `busy_o`, output, 1: high whenever state ≠ IDLE.
- `done_o`, output, 1: one-cycle pulse after the last beat is accepted.
- `rf_addr_o`, output, NRegWidth: read address driven to the regfile's read port.
- `rf_data_i`, input, XLen: combinational read data returned for `rf_addr_o`. Register 0 reads as 0.
- `m_valid_o`, output, 1: output beat valid.
- `m_ready_i`, input, 1: sink accepts the beat.
- `m_addr_o`, output, NRegWidth: register index of the current beat.
- `m_data_o`, output, XLen: register value of the current beat.
- `m_last_o`, output, 1: high on the beat for index NReg-1.

## Operation

- **Reset values.** On `rst_i` all outputs are 0 and the state is IDLE. The index counter is 0 and the output register is empty.
- **States:** IDLE, DUMP, DRAIN.
- **IDLE → DUMP** on `start_i`. The index counter `idx` clears to 0.
- **DUMP.**
  - `rf_addr_o = idx`.
  - Load condition: `load = !m_valid_o || m_ready_i`.
  - On `load`, the output register captures `{idx, rf_data_i, idx == NReg-1}` and sets `m_valid_o`. `idx` then increments.
  - If the loaded index was NReg-1, go to DRAIN.
- **DRAIN.** Wait for `m_valid_o && m_ready_i`. Then clear `m_valid_o`, pulse `done_o`, and return to IDLE.
- **Accept without reload.** An accept with no new load (DRAIN, or IDLE) clears `m_valid_o`.
- **Handshake rules.**
  - Once `m_valid_o` is high, `m_addr_o`, `m_data_o` and `m_last_o` stay stable until accepted.
  - `m_valid_o` never drops without an accept, except on reset.
- **`start_i` while busy** is ignored. No queuing, no restart.
- **`rf_addr_o` outside DUMP** holds 0.
- **Snapshot semantics.** Each value is sampled on the cycle it is loaded. A regfile write to index k that lands before k's load cycle is visible in the dump; one that lands after is not. Writes during the load cycle are not visible, because the read is combinational off pre-edge state.
- **Reset mid-dump.** Return to IDLE immediately, drop `m_valid_o`, and do not pulse `done_o`.
- **Index counter width.** The counter is NRegWidth bits. Detect the end by comparing to NReg-1, not by overflow.

## Timing

- **Start.** `start_i` is sampled at edge E0, and DUMP begins in the cycle after E0 with `rf_addr_o = 0`.
- **First beat.** Beat 0 is valid after E1, which gives a start-to-first-valid latency of 2 edges.
- **Throughput.** With `m_ready_i` held high, the block delivers one beat per cycle. Beat NReg-1 is valid after E_NReg and is accepted at E_NReg+1.
- **Completion.** In the cycle after E_NReg+1, `done_o` = 1 and `busy_o` = 0.
- **Backpressure.** `m_ready_i` low stalls `idx` and holds the output. There are no bubbles beyond the stall.
- **Next dump.** A new `start_i` may be applied in the same cycle `done_o` is high.

## Structure

- Shared package `regfile_pkg`:
  - `XLen` and `NReg` defaults.
  - `dump_state_e` enum {IDLE, DUMP, DRAIN}.
  - `dump_beat_t` packed struct {addr, data, last}.
- The whole block is one module: the FSM, index counter and one-entry output register. No sub-module; the output register is too small to justify one.

## Test plan

- **Basic dump.** Reset, preload `rf[i] = 0x100 + i` (rf[0] reads 0), pulse `start_i`, hold `m_ready_i = 1`.
  - 32 beats with addr 0..31.
  - data 0, 0x101 … 0x11F.
  - `m_last_o` only on addr 31.
  - `done_o` one cycle after the addr-31 accept; first valid 2 edges after start.
- **Backpressure.** Toggle `m_ready_i` pseudo-randomly (seed fixed).
  - Same 32 beats in order, with no duplicates or drops.
  - Payload stable while `valid && !ready`.
- **Start while busy.** Pulse `start_i` mid-dump at beat 10.
  - Exactly 32 beats and a single `done_o`.
- **Concurrent write.** With ready held high, write `rf[20] = 0xDEAD` at the cycle `rf_addr_o = 5`, and `rf[3] = 0xBEEF` at the same time.
  - Beat 20 = 0xDEAD.
  - Beat 3 keeps its old value.
- **Reset mid-operation.** Assert `rst_i` with `m_valid_o = 1` at beat 12.
  - Next cycle: all outputs 0, `busy_o = 0`, no `done_o`.
  - A subsequent start yields a full 0..31 dump.
- **Back-to-back starts.** Assert `start_i` in the `done_o` cycle.
  - A second complete dump begins, first valid 2 edges later.
